// File: rtl/lift_seq_if.sv
// rtl/lift_seq_if.sv - even/odd RAM bank port bundle for the lifting sequencer
interface lift_seq_if #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] addr_even;
  logic [ADDR_W-1:0] addr_odd;
  logic              we_even;
  logic              we_odd;
  logic [DATA_W-1:0] din_even;
  logic [DATA_W-1:0] din_odd;
  logic [DATA_W-1:0] dout_even;
  logic [DATA_W-1:0] dout_odd;

  modport master (
    output addr_even, addr_odd, we_even, we_odd, din_even, din_odd,
    input  dout_even, dout_odd
  );

  modport slave (
    input  addr_even, addr_odd, we_even, we_odd, din_even, din_odd,
    output dout_even, dout_odd
  );
endinterface

// File: rtl/lift_seq.sv
// rtl/lift_seq.sv - 5/3 lifting row sequencer: predict/update passes over the even/odd banks
module lift_seq #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fwd_inv,
  input  logic [ADDR_W-1:0] half_len_m1,
  lift_seq_if.master        ram,
  output logic              phase,
  output logic              busy,
  output logic              done
);
  localparam int EW = DATA_W + 2;
  localparam logic signed [EW-1:0] ROUND = {{(EW-2){1'b0}}, 2'b10};

  typedef enum logic [2:0] {
    IDLE, PASS1_A, PASS1_B, PASS1_C, PASS2_A, PASS2_B, PASS2_C, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt, last, last_nxt, idx_up, idx_dn;
  logic              fwd, fwd_nxt, in_pass1, in_pass2, upd_nxt;
  logic [ADDR_W-1:0] addr_even_q, addr_odd_q, addr_even_nxt, addr_odd_nxt;
  logic              we_even_q, we_odd_q, we_even_nxt, we_odd_nxt;
  logic              phase_nxt, busy_nxt, done_nxt;
  logic [DATA_W-1:0] e_op, o_op;
  logic signed [EW-1:0] e_x, o_x, de_x, do_x, term;
  logic [DATA_W-1:0] res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      last        <= '0;
      fwd         <= 1'b0;
      addr_even_q <= '0;
      addr_odd_q  <= '0;
      we_even_q   <= 1'b0;
      we_odd_q    <= 1'b0;
      phase       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      e_op        <= '0;
      o_op        <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      last        <= last_nxt;
      fwd         <= fwd_nxt;
      addr_even_q <= addr_even_nxt;
      addr_odd_q  <= addr_odd_nxt;
      we_even_q   <= we_even_nxt;
      we_odd_q    <= we_odd_nxt;
      phase       <= phase_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      // Slot-A reads land during slot B; the slot-B read is consumed live in slot C.
      if (state == PASS1_B || state == PASS2_B) begin
        e_op <= ram.dout_even;
        o_op <= ram.dout_odd;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    last_nxt  = last;
    fwd_nxt   = fwd;
    case (state)
      IDLE: if (start) begin
        state_nxt = PASS1_A;
        idx_nxt   = '0;
        last_nxt  = half_len_m1;
        fwd_nxt   = fwd_inv;
      end
      PASS1_A: state_nxt = PASS1_B;
      PASS1_B: state_nxt = PASS1_C;
      PASS1_C: begin
        state_nxt = (idx == last) ? PASS2_A : PASS1_A;
        idx_nxt   = (idx == last) ? '0 : idx + ADDR_W'(1);
      end
      PASS2_A: state_nxt = PASS2_B;
      PASS2_B: state_nxt = PASS2_C;
      PASS2_C: begin
        state_nxt = (idx == last) ? DONE : PASS2_A;
        idx_nxt   = (idx == last) ? '0 : idx + ADDR_W'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    in_pass1 = (state_nxt == PASS1_A) || (state_nxt == PASS1_B) || (state_nxt == PASS1_C);
    in_pass2 = (state_nxt == PASS2_A) || (state_nxt == PASS2_B) || (state_nxt == PASS2_C);
    upd_nxt  = in_pass2 ? fwd_nxt : ~fwd_nxt;
    idx_up   = (idx_nxt == last_nxt) ? idx_nxt : idx_nxt + ADDR_W'(1);
    idx_dn   = (idx_nxt == '0) ? '0 : idx_nxt - ADDR_W'(1);

    addr_even_nxt = '0;
    addr_odd_nxt  = '0;
    we_even_nxt   = 1'b0;
    we_odd_nxt    = 1'b0;
    case (state_nxt)
      PASS1_A, PASS2_A: begin
        addr_even_nxt = idx_nxt;
        addr_odd_nxt  = upd_nxt ? idx_dn : idx_nxt;
      end
      PASS1_B, PASS2_B: begin
        addr_even_nxt = upd_nxt ? idx_nxt : idx_up;
        addr_odd_nxt  = idx_nxt;
      end
      PASS1_C, PASS2_C: begin
        addr_even_nxt = idx_nxt;
        addr_odd_nxt  = idx_nxt;
        we_even_nxt   = upd_nxt;
        we_odd_nxt    = ~upd_nxt;
      end
      default: ;
    endcase
    phase_nxt = (in_pass1 || in_pass2) && upd_nxt;
    busy_nxt  = in_pass1 || in_pass2;
    done_nxt  = (state_nxt == DONE);
  end

  assign e_x  = {{2{e_op[DATA_W-1]}}, e_op};
  assign o_x  = {{2{o_op[DATA_W-1]}}, o_op};
  assign de_x = {{2{ram.dout_even[DATA_W-1]}}, ram.dout_even};
  assign do_x = {{2{ram.dout_odd[DATA_W-1]}}, ram.dout_odd};

  // Predict: o_x=o[i], e_x=e[i], de_x=e[i+1]. Update: o_x=o[i-1], do_x=o[i], e_x=e[i].
  always_comb begin
    term = '0;
    res  = '0;
    if (we_odd_q) begin
      term = (e_x + de_x) >>> 1;
      res  = DATA_W'(fwd ? o_x - term : o_x + term);
    end else if (we_even_q) begin
      term = (o_x + do_x + ROUND) >>> 2;
      res  = DATA_W'(fwd ? e_x + term : e_x - term);
    end
  end

  assign ram.addr_even = addr_even_q;
  assign ram.addr_odd  = addr_odd_q;
  assign ram.we_even   = we_even_q;
  assign ram.we_odd    = we_odd_q;
  assign ram.din_even  = we_even_q ? res : '0;
  assign ram.din_odd   = we_odd_q ? res : '0;
endmodule

// File: tb/tb_lift_seq.sv
// tb/tb_lift_seq.sv - randomized self-checking bench for lift_seq with a behavioural row model
module tb_lift_seq;
  localparam int DW = 9;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst, start, fwd_inv;
  logic [AW-1:0] half_len_m1;
  logic          phase, busy, done;

  always #5 clk = ~clk;

  lift_seq_if #(.DATA_W(DW), .ADDR_W(AW)) ram ();

  lift_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .fwd_inv(fwd_inv), .half_len_m1(half_len_m1),
    .ram(ram), .phase(phase), .busy(busy), .done(done)
  );

  // Two RAM banks with 1-cycle read latency and a bench-side load port.
  logic [DW-1:0] mem_e [128];
  logic [DW-1:0] mem_o [128];
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_e, load_o;

  always @(posedge clk) begin
    if (load_en) begin
      mem_e[load_addr] <= load_e;
      mem_o[load_addr] <= load_o;
    end else begin
      if (ram.we_even) mem_e[ram.addr_even] <= ram.din_even;
      if (ram.we_odd)  mem_o[ram.addr_odd]  <= ram.din_odd;
    end
    ram.dout_even <= mem_e[ram.addr_even];
    ram.dout_odd  <= mem_o[ram.addr_odd];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wrap9(input int x);
    logic signed [DW-1:0] t;
    t = x[DW-1:0];
    return int'(t);
  endfunction

  // Behavioural row model: result arrays computed from the lifting equations at start acceptance.
  int  m_T, m_H;
  bit  m_fwd, m_active, since_rst;
  int  wk_e [128];
  int  wk_o [128];
  int  p_exp [128];
  int  u_exp [128];
  int  fin_e [128];
  int  fin_o [128];
  int  wr_cnt, done_cnt, done_cyc, max_addr;

  always @(posedge clk) begin
    if (rst) begin
      m_active  = 1'b0;
      since_rst = 1'b1;
    end else if (start && (!m_active || cyc >= m_T + 6 * m_H + 2)) begin
      m_T   = cyc;
      m_H   = int'(half_len_m1) + 1;
      m_fwd = fwd_inv;
      for (int i = 0; i < 128; i++) begin
        wk_e[i] = int'($signed(mem_e[i]));
        wk_o[i] = int'($signed(mem_o[i]));
      end
      if (m_fwd) begin
        for (int i = 0; i < m_H; i++) begin
          wk_o[i]  = wrap9(wk_o[i] - ((wk_e[i] + wk_e[(i + 1 < m_H) ? i + 1 : m_H - 1]) >>> 1));
          p_exp[i] = wk_o[i];
        end
        for (int i = 0; i < m_H; i++) begin
          wk_e[i]  = wrap9(wk_e[i] + ((wk_o[(i > 0) ? i - 1 : 0] + wk_o[i] + 2) >>> 2));
          u_exp[i] = wk_e[i];
        end
      end else begin
        for (int i = 0; i < m_H; i++) begin
          wk_e[i]  = wrap9(wk_e[i] - ((wk_o[(i > 0) ? i - 1 : 0] + wk_o[i] + 2) >>> 2));
          u_exp[i] = wk_e[i];
        end
        for (int i = 0; i < m_H; i++) begin
          wk_o[i]  = wrap9(wk_o[i] + ((wk_e[i] + wk_e[(i + 1 < m_H) ? i + 1 : m_H - 1]) >>> 1));
          p_exp[i] = wk_o[i];
        end
      end
      for (int i = 0; i < 128; i++) begin
        fin_e[i] = wk_e[i];
        fin_o[i] = wk_o[i];
      end
      m_active  = 1'b1;
      since_rst = 1'b0;
      wr_cnt    = 0;
      done_cnt  = 0;
      max_addr  = 0;
    end
  end

  // Per-cycle compare against the row timeline: cycle T+k, slot=(k-1)%3, pass=(k-1)/(3H).
  bit chk_en = 1'b0;
  int k, slot, pass, ix;
  bit upd;

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      k = cyc - m_T;
      if (m_active && k >= 1 && k <= 6 * m_H) begin
        slot = (k - 1) % 3;
        pass = (k - 1) / (3 * m_H);
        ix   = ((k - 1) % (3 * m_H)) / 3;
        upd  = (pass == 0) ? !m_fwd : m_fwd;
        chk("busy", busy, 1);
        chk("done_early", done, 0);
        chk("phase", phase, upd);
        chk("we_even", ram.we_even, (slot == 2) && upd);
        chk("we_odd", ram.we_odd, (slot == 2) && !upd);
        chk("addr_even_range", int'(ram.addr_even) < m_H, 1);
        chk("addr_odd_range", int'(ram.addr_odd) < m_H, 1);
        if (int'(ram.addr_even) > max_addr) max_addr = int'(ram.addr_even);
        if (int'(ram.addr_odd) > max_addr)  max_addr = int'(ram.addr_odd);
        if (slot == 0) begin
          chk("a_addr_even", ram.addr_even, ix);
          chk("a_addr_odd", ram.addr_odd, upd ? ((ix > 0) ? ix - 1 : 0) : ix);
        end else if (slot == 1) begin
          if (upd) chk("b_addr_odd", ram.addr_odd, ix);
          else     chk("b_addr_even", ram.addr_even, (ix + 1 < m_H) ? ix + 1 : m_H - 1);
        end else if (upd) begin
          chk("c_addr_even", ram.addr_even, ix);
          chk("din_even", ram.din_even, u_exp[ix] & 511);
        end else begin
          chk("c_addr_odd", ram.addr_odd, ix);
          chk("din_odd", ram.din_odd, p_exp[ix] & 511);
        end
      end else if (m_active && k == 6 * m_H + 1) begin
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 0);
        chk("we_in_done", {ram.we_even, ram.we_odd}, 0);
      end else begin
        chk("busy_idle", busy, 0);
        chk("done_idle", done, 0);
        chk("we_idle", {ram.we_even, ram.we_odd}, 0);
        if (since_rst) begin
          chk("rst_addr", {ram.addr_even, ram.addr_odd}, 0);
          chk("rst_phase", phase, 0);
          chk("rst_din", {ram.din_even, ram.din_odd}, 0);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ram.we_even || ram.we_odd) wr_cnt++;
    end
  end

  int init_e [128];
  int init_o [128];
  int lit_e  [4] = '{0, 2, 4, 6};
  int lit_o1 [4] = '{1, 3, 5, 7};
  int lit_o0 [4] = '{0, 0, 0, 1};

  task automatic load_rows(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_e    = DW'(init_e[i]);
      load_o    = DW'(init_o[i]);
    end
    @(negedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic rand_rows(input int n);
    for (int i = 0; i < n; i++) begin
      init_e[i] = int'($urandom_range(0, 511)) - 256;
      init_o[i] = int'($urandom_range(0, 511)) - 256;
    end
    load_rows(n);
  endtask

  task automatic issue_start(input bit f, input int h);
    @(negedge clk); #1;
    start       = 1'b1;
    fwd_inv     = f;
    half_len_m1 = AW'(h - 1);
    @(negedge clk); #1;
    start       = 1'b0;
    fwd_inv     = ~f;
    half_len_m1 = AW'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic check_mem(input int h);
    for (int i = 0; i < h; i++) begin
      chk("mem_even", mem_e[i], fin_e[i] & 511);
      chk("mem_odd", mem_o[i], fin_o[i] & 511);
    end
  endtask

  task automatic check_restore(input int h);
    for (int i = 0; i < h; i++) begin
      chk("restore_even", mem_e[i], init_e[i] & 511);
      chk("restore_odd", mem_o[i], init_o[i] & 511);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; fwd_inv = 1'b0; half_len_m1 = '0;
    load_en = 1'b0; load_addr = '0; load_e = '0; load_o = '0;
    repeat (3) @(negedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Forward ramp, then its inverse.
    for (int i = 0; i < 4; i++) begin
      init_e[i] = lit_e[i];
      init_o[i] = lit_o1[i];
    end
    load_rows(4);
    issue_start(1'b1, 4);
    wait_done();
    check_mem(4);
    for (int i = 0; i < 4; i++) begin
      chk("ramp_even", mem_e[i], lit_e[i]);
      chk("ramp_odd", mem_o[i], lit_o0[i]);
    end
    chk("ramp_done_latency", done_cyc - m_T, 25);
    chk("ramp_writes", wr_cnt, 8);
    issue_start(1'b0, 4);
    wait_done();
    check_mem(4);
    check_restore(4);

    // Random H=64 round trip.
    rand_rows(64);
    issue_start(1'b1, 64);
    wait_done();
    check_mem(64);
    issue_start(1'b0, 64);
    wait_done();
    check_mem(64);
    check_restore(64);

    // Wrap and H=1 mirror on both sides.
    init_e[0] = 255;
    init_o[0] = -256;
    load_rows(1);
    issue_start(1'b1, 1);
    wait_done();
    check_mem(1);
    chk("wrap_odd", mem_o[0], 1);
    chk("wrap_even", mem_e[0], 256);
    chk("wrap_done_latency", done_cyc - m_T, 7);

    // Full depth round trip.
    rand_rows(128);
    issue_start(1'b1, 128);
    wait_done();
    check_mem(128);
    chk("full_done_latency", done_cyc - m_T, 769);
    chk("full_max_addr", max_addr, 127);
    issue_start(1'b0, 128);
    wait_done();
    check_mem(128);
    check_restore(128);

    // start while busy is ignored.
    rand_rows(8);
    issue_start(1'b1, 8);
    wait_until(m_T + 10);
    start       = 1'b1;
    fwd_inv     = 1'b0;
    half_len_m1 = AW'(2);
    @(negedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);
    #1;
    chk("busy_start_done_count", done_cnt, 1);
    chk("busy_start_latency", done_cyc - m_T, 49);
    check_mem(8);

    // Mid-row reset, then a fresh row.
    rand_rows(4);
    issue_start(1'b1, 4);
    wait_until(m_T + 5);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("rst_busy_drop", busy, 0);
    repeat (8) @(negedge clk);
    #1;
    rand_rows(4);
    issue_start(1'b1, 4);
    wait_done();
    check_mem(4);
    chk("post_rst_latency", done_cyc - m_T, 25);
    chk("post_rst_writes", wr_cnt, 8);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lift_seq.md
# lift_seq

Sequencer for one row of the 5/3 integer lifting transform over the even/odd pixel RAM pair (`ram_even` banks, 128 x 9-bit each). It runs the predict pass and then the update pass, or the reverse order for the inverse transform. For each pass it issues read addresses, gathers operands across the 1-cycle RAM read latency, computes the lifting result, and writes it back in place. It sits between the row/column scheduler, which pulses `start`, and the two RAM banks, and it owns both bank ports while `busy` is high.

## Interface
- `DATA_W`, 9: sample width, signed two's complement.
- `ADDR_W`, 7: bank address width; bank depth is 2**ADDR_W.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to process a row; accepted only in IDLE.
- `fwd_inv` in 1: 1 = forward transform, 0 = inverse; latched on start.
- `half_len_m1` in ADDR_W: samples per bank minus 1 (0..127); latched on start.
- `addr_even` out ADDR_W: even bank address.
- `addr_odd` out ADDR_W: odd bank address.
- `we_even` out 1: even bank write enable.
- `we_odd` out 1: odd bank write enable.
- `din_even` out DATA_W: even bank write data.
- `din_odd` out DATA_W: odd bank write data.
- `dout_even` in DATA_W: even bank read data, valid 1 cycle after its address.
- `dout_odd` in DATA_W: odd bank read data, valid 1 cycle after its address.
- `phase` out 1: 0 = predict pass active, 1 = update pass active.
- `busy` out 1: controller owns the RAMs.
- `done` out 1: one-cycle pulse when the row is complete.

## Operation
- **FSM states:** IDLE → PASS1_A/B/C → PASS2_A/B/C → DONE → IDLE. The A/B/C slots repeat once per index i = 0..H-1, where H = half_len_m1+1.
- **Pass order:** forward runs PASS1 = predict, PASS2 = update. Inverse runs PASS1 = update, PASS2 = predict.
- **Predict at index i:**
  - A: addr_even=i, addr_odd=i.
  - B: addr_even=min(i+1,H-1).
  - C: compute p=(e[i]+e[i+1])>>>1. Forward writes odd[i]=o[i]-p; inverse writes odd[i]=o[i]+p. we_odd=1 and addr_odd=i.
- **Update at index i:**
  - A: addr_even=i, addr_odd=max(i-1,0).
  - B: addr_odd=i.
  - C: compute u=(o[i-1]+o[i]+2)>>>2. Forward writes even[i]=e[i]+u; inverse writes even[i]=e[i]-u. we_even=1 and addr_even=i.
- **Symmetric extension:** the predict pass uses e[H]=e[H-1]. The update pass uses o[-1]=o[0].
- **Arithmetic:**
  - Operands are sign-extended to DATA_W+2 bits.
  - Shifts are arithmetic.
  - The result is truncated to DATA_W bits (wrap, no saturation).
- **Write enables:** only the bank being written in slot C has its write enable asserted. Both enables are 0 in A and B slots, in IDLE and in DONE.
- **start while busy or in DONE:** ignored. Latched fwd_inv and half_len_m1 are unaffected.
- **rst at any point:**
  - Next state is IDLE.
  - All outputs take their reset values at the next edge.
  - No further writes occur. A write already presented in the same cycle as rst is still committed by the RAM.

## Timing
- **Reset values:** addr_even=0, addr_odd=0, we_even=0, we_odd=0, din_even=0, din_odd=0, phase=0, busy=0, done=0.
- **Row timing** (start sampled high in IDLE at edge T):
  - busy=1 from cycle T+1 through T+6H.
  - PASS1 occupies cycles T+1..T+3H; PASS2 occupies T+3H+1..T+6H.
  - done=1 and busy=0 in cycle T+6H+1.
  - A new start is accepted from cycle T+6H+2.
- **phase:** follows the pass kind, not the pass number. Forward: phase=0 during PASS1. Inverse: phase=1 during PASS1.
- **Outputs are registered.** Address and write data in slot C are presented with the write enable in the same cycle. The RAM commits at the edge ending that cycle.
- **No hazards:** a pass never reads a location it has already written.

## Test plan
- **Forward ramp:** H=4, even={0,2,4,6}, odd={1,3,5,7}, fwd_inv=1 → odd={0,0,0,1}, even={0,2,4,6}; done exactly at T+25; exactly 8 write cycles.
- **Inverse round trip:** run the inverse on the ramp result → even={0,2,4,6}, odd={1,3,5,7} restored. Repeat with 64 random 9-bit pairs (H=64) → bit-exact restore.
- **Wrap:** H=1, even[0]=255, odd[0]=-256, forward → odd[0]=1 (wrapped), even[0]=255+((1+1+2)>>>2)=256→-256. Also checks the H=1 mirror on both sides; done at T+7.
- **Full depth:** half_len_m1=127 → addresses reach 127 and never exceed it; done at T+769; max(i-1,0) used at i=0.
- **start while busy:** pulse start at T+10 with different fwd_inv → no effect; single done at T+6H+1.
- **Mid-row reset:** assert rst at T+5 → next cycle busy=0, both write enables 0, addresses 0; no writes afterwards; a fresh start then completes normally.
